uart_bus_arbiter: RTL and testbench
===================================

# uart_bus_arbiter

Two-requester arbiter and access sequencer in front of the memory-mapped UART register block (status at address 0, TX/RX data at address 1). It shares the single UART bus between the CPU and the debug/boot loader using round-robin arbitration. Data-register accesses are guarded by a status poll so no requester writes a full TX FIFO or pops an empty RX FIFO. Guard failures release the bus so the other requester can proceed; this prevents deadlock.

## Interface
- MAX_RETRY, 255: guard failures tolerated per transaction before an error completion; 8-bit; 0 = unlimited.
- CLK  in  1  clock
- reset  in  1  reset, synchronous, active-high; clock CLK
- req  in  2  per-requester request; held with fields stable until ack
- req_wr  in  2  per-requester write (1) / read (0)
- req_addr  in  4  {addr1[1:0], addr0[1:0]} register address
- req_wdata  in  64  {wdata1, wdata0}
- ack  out  2  one-cycle completion pulse, one bit per requester
- err  out  1  valid with ack; retry limit hit, no data access performed
- rdata  out  32  valid with ack for reads; 0 for writes and errors
- uart_addr  out  2  to UART block addr
- uart_data_in  out  32  to UART block data_in
- uart_en  out  1  to UART block en
- uart_wr  out  1  to UART block wr
- uart_data_out  in  32  from UART block; registered, valid the cycle after the addressed cycle

## Operation
- States: IDLE, STAT, CHECK, ACCESS, RDATA.
- IDLE: if any req is set, grant and latch addr/wr/wdata, then update last_grant. Both requesting → grant the one not equal to last_grant. last_grant resets to 1, so requester 0 wins first.
- Guarded = addr 1; go to STAT. Unguarded (addr 0, 2, 3) → ACCESS.
- STAT: uart_addr=0, uart_en=1, uart_wr=0. CHECK: uart_addr=0, uart_en=0; sample uart_data_out.
- Guard: write needs bit31 (tx_full)=0; read needs bit30 (rx_empty)=0.
- Guard pass → ACCESS.
- Guard fail, below limit → increment the granted requester's retry counter and return to IDLE without ack.
- Guard fail, counter+1 == MAX_RETRY (MAX_RETRY≠0) → ack with err=1, rdata=0, clear counter, return to IDLE.
- ACCESS: uart_addr=latched addr, uart_en=1, uart_wr=latched wr, uart_data_in=latched wdata. Write → ack, then IDLE. Read → RDATA.
- RDATA: uart_en=0, uart_addr held; rdata=uart_data_out, ack, then IDLE. The retry counter of the completing requester is cleared on every ack.
- uart_en is 1 only in STAT and ACCESS. uart_wr is 1 only in ACCESS for writes. Exactly one data-register access occurs per successful transaction.
- Two retry counters, one per requester, each 8 bits. A requester's counter persists across the other's transactions.
- A request dropped before ack still completes: the latched transaction runs, and ack pulses regardless.
- Writes to addresses 0, 2 and 3 are acked without effect. Reads of addresses 2 and 3 return 0.

## Timing
- Grant cycle G (IDLE).
- Guarded write: STAT G+1, CHECK G+2, ACCESS + ack G+3.
- Guarded read: ack at G+4.
- Unguarded write: ack at G+1. Unguarded read: ack at G+2.
- Guard fail: IDLE at G+3, so re-arbitration happens at G+3.
- Back-to-back: a new grant is possible in the cycle after ack.
- Reset: state=IDLE, last_grant=1, counters=0, ack=0, err=0, rdata=0, uart_en=0, uart_wr=0, uart_addr=0, uart_data_in=0.
- Reset mid-transaction: abort with no ack; uart_en=0 from the next cycle.
- All outputs decode from registered state and latched fields. No combinational path from req to uart_*.

## Structure
- Package uart_arb_pkg: state enum; UART_ADDR_STATUS=2'd0, UART_ADDR_DATA=2'd1; STAT_TX_FULL_BIT=31, STAT_RX_EMPTY_BIT=30.
- One natural sub-module: rr_arb2 (2-way round-robin picker: req[1:0] and last_grant in; grant index and valid out). Everything else stays in the top level.

## Test plan
- Requester 0 writes 0x41 to addr 1, TX not full: status read at G+1; one en+wr access at addr 1 with data 0x41 at G+3; ack[0] at G+3, err=0.
- Both request reads of addr 0 in the same cycle after reset: requester 0 acks first at G+2 with the status word. Requester 1 is granted next cycle and acks 2 cycles later.
- Requester 1 reads addr 1 with rx_empty=1 while requester 0 writes: requester 1 fails its guard and returns to IDLE. Requester 0 is granted at G+3 and completes. Requester 1 completes once a byte arrives, with rdata=0x000000xx.
- MAX_RETRY=3, TX held full, requester 0 writes: three guard failures, then ack[0] with err=1. No cycle has uart_en=1 with uart_wr=1.
- Reset asserted during CHECK: no ack, uart_en=0 next cycle. After release, requester 0 wins the first tie.
- Read of addr 3: ack at G+2 with rdata=0. Write of addr 2: ack at G+1, no status poll.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART bus arbiter: sequencer states,
// UART register map and status-word bit positions.
package uart_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    STAT,
    CHECK,
    ACCESS,
    RDATA
  } state_t;

  localparam logic [1:0] UART_ADDR_STATUS  = 2'd0;
  localparam logic [1:0] UART_ADDR_DATA    = 2'd1;
  localparam int         STAT_TX_FULL_BIT  = 31;
  localparam int         STAT_RX_EMPTY_BIT = 30;

  // A write needs room in the TX FIFO; a read needs a byte in the RX FIFO.
  function automatic logic guard_ok(input logic wr, input logic [31:0] status);
    return wr ? !status[STAT_TX_FULL_BIT] : !status[STAT_RX_EMPTY_BIT];
  endfunction

endpackage

// File: rtl/uart_bus_arbiter_rr_arb2.sv
// Two-way round-robin picker: on a tie the requester that did not win last
// time is chosen.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant,
  output logic       valid
);

  always_comb begin
    valid = |req;
    if (req == 2'b11) grant = ~last_grant;
    else              grant = req[1];
  end

endmodule

// File: rtl/uart_bus_arbiter.sv
// Shares the UART register bus between two requesters; data-register
// accesses are preceded by a status poll and released on guard failure.
module uart_bus_arbiter
  import uart_arb_pkg::*;
#(
  parameter logic [7:0] MAX_RETRY = 8'd255
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic [1:0]  req,
  input  logic [1:0]  req_wr,
  input  logic [3:0]  req_addr,
  input  logic [63:0] req_wdata,
  output logic [1:0]  ack,
  output logic        err,
  output logic [31:0] rdata,
  output logic [1:0]  uart_addr,
  output logic [31:0] uart_data_in,
  output logic        uart_en,
  output logic        uart_wr,
  input  logic [31:0] uart_data_out
);

  state_t      state, state_nxt;
  logic        last_grant;
  logic        gnt_idx;
  logic        l_wr;
  logic [1:0]  l_addr;
  logic [31:0] l_wdata;
  logic [7:0]  retry_cnt [2];

  logic        arb_grant, arb_valid;
  logic [1:0]  arb_addr;
  logic        guard_pass;
  logic [7:0]  retry_next;
  logic        limit_hit;

  rr_arb2 u_rr_arb2 (
    .req        (req),
    .last_grant (last_grant),
    .grant      (arb_grant),
    .valid      (arb_valid)
  );

  assign arb_addr   = arb_grant ? req_addr[3:2] : req_addr[1:0];
  assign guard_pass = guard_ok(l_wr, uart_data_out);
  assign retry_next = retry_cnt[gnt_idx] + 8'd1;
  assign limit_hit  = (MAX_RETRY != 8'd0) && (retry_next == MAX_RETRY);

  always_ff @(posedge CLK) begin
    if (reset) begin
      state        <= IDLE;
      last_grant   <= 1'b1;
      gnt_idx      <= 1'b0;
      l_wr         <= 1'b0;
      l_addr       <= 2'd0;
      l_wdata      <= 32'd0;
      retry_cnt[0] <= 8'd0;
      retry_cnt[1] <= 8'd0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && arb_valid) begin
        gnt_idx    <= arb_grant;
        last_grant <= arb_grant;
        l_wr       <= req_wr[arb_grant];
        l_addr     <= arb_addr;
        l_wdata    <= arb_grant ? req_wdata[63:32] : req_wdata[31:0];
      end
      // Any completion, good or error, starts the requester's retry budget over.
      if (|ack)
        retry_cnt[gnt_idx] <= 8'd0;
      else if (state == CHECK && !guard_pass)
        retry_cnt[gnt_idx] <= retry_next;
    end
  end

  always_comb begin
    state_nxt    = state;
    ack          = 2'b00;
    err          = 1'b0;
    rdata        = 32'd0;
    uart_addr    = UART_ADDR_STATUS;
    uart_data_in = 32'd0;
    uart_en      = 1'b0;
    uart_wr      = 1'b0;
    case (state)
      IDLE: begin
        if (arb_valid)
          state_nxt = (arb_addr == UART_ADDR_DATA) ? STAT : ACCESS;
      end
      STAT: begin
        uart_en   = 1'b1;
        state_nxt = CHECK;
      end
      CHECK: begin
        if (guard_pass) begin
          state_nxt = ACCESS;
        end else begin
          state_nxt = IDLE;
          if (limit_hit) begin
            ack[gnt_idx] = 1'b1;
            err          = 1'b1;
          end
        end
      end
      ACCESS: begin
        uart_addr    = l_addr;
        uart_en      = 1'b1;
        uart_wr      = l_wr;
        uart_data_in = l_wdata;
        if (l_wr) begin
          ack[gnt_idx] = 1'b1;
          state_nxt    = IDLE;
        end else begin
          state_nxt = RDATA;
        end
      end
      RDATA: begin
        uart_addr    = l_addr;
        ack[gnt_idx] = 1'b1;
        // Addresses 2 and 3 are unimplemented and always read as zero.
        if (l_addr == UART_ADDR_STATUS || l_addr == UART_ADDR_DATA)
          rdata = uart_data_out;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_bus_arbiter.sv
// Directed bench for uart_bus_arbiter with a small behavioural UART register
// block; each scenario checks its own hand-computed cycle-level results.
module tb_uart_bus_arbiter;

  logic        CLK = 1'b0;
  logic        reset;
  logic [1:0]  req, req_wr;
  logic [1:0]  a0, a1;
  logic [31:0] w0, w1;
  logic [1:0]  ack;
  logic        err;
  logic [31:0] rdata;
  logic [1:0]  uart_addr;
  logic [31:0] uart_data_in;
  logic        uart_en, uart_wr;
  logic [31:0] uart_data_out;

  logic        tx_full, rx_empty;
  logic [7:0]  rx_byte;
  int          wr_count;
  logic [31:0] last_wdata;
  logic [1:0]  last_waddr;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  uart_bus_arbiter #(.MAX_RETRY(8'd3)) dut (
    .CLK           (CLK),
    .reset         (reset),
    .req           (req),
    .req_wr        (req_wr),
    .req_addr      ({a1, a0}),
    .req_wdata     ({w1, w0}),
    .ack           (ack),
    .err           (err),
    .rdata         (rdata),
    .uart_addr     (uart_addr),
    .uart_data_in  (uart_data_in),
    .uart_en       (uart_en),
    .uart_wr       (uart_wr),
    .uart_data_out (uart_data_out)
  );

  // Behavioural UART register block: registered read data, write log.
  initial begin
    uart_data_out = 32'd0;
    wr_count      = 0;
    last_wdata    = 32'd0;
    last_waddr    = 2'd0;
  end
  always @(posedge CLK) begin
    if (uart_en) begin
      if (uart_wr) begin
        wr_count   <= wr_count + 1;
        last_wdata <= uart_data_in;
        last_waddr <= uart_addr;
      end else begin
        case (uart_addr)
          2'd0:    uart_data_out <= {tx_full, rx_empty, 30'd0};
          2'd1:    uart_data_out <= {24'd0, rx_byte};
          default: uart_data_out <= 32'hDEADBEEF;
        endcase
      end
    end
  end

  task step;
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task idle_inputs;
    req = 2'b00; req_wr = 2'b00; a0 = 2'd0; a1 = 2'd0; w0 = 32'd0; w1 = 32'd0;
  endtask

  task do_reset;
    reset = 1'b1;
    idle_inputs();
    step(); step();
    reset = 1'b0;
  endtask

  task wait_ack(input logic [1:0] which, input int bound, output int cyc);
    cyc = 0;
    while (ack !== which && cyc < bound) begin
      step();
      cyc++;
    end
  endtask

  task test_reset;
    tx_full = 1'b0; rx_empty = 1'b1; rx_byte = 8'h00;
    do_reset();
    checks++;
    if ({ack, err, uart_en, uart_wr} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl got %b exp 00000", {ack, err, uart_en, uart_wr});
    end
    checks++;
    if ({rdata, uart_addr, uart_data_in} !== 66'd0) begin
      errors++; $display("FAIL reset_data got %h/%h/%h exp 0", rdata, uart_addr, uart_data_in);
    end
  endtask

  task test_guarded_write;
    int n0;
    do_reset();
    tx_full = 1'b0;
    n0 = wr_count;
    req = 2'b01; req_wr = 2'b01; a0 = 2'd1; w0 = 32'h41;
    checks++;
    if (uart_en !== 1'b0 || ack !== 2'b00) begin
      errors++; $display("FAIL gw_g got en=%b ack=%b exp 0/00", uart_en, ack);
    end
    step();
    checks++;
    if ({uart_en, uart_wr, uart_addr, ack} !== 6'b10_00_00) begin
      errors++; $display("FAIL gw_stat got %b exp 100000", {uart_en, uart_wr, uart_addr, ack});
    end
    step();
    checks++;
    if (uart_en !== 1'b0 || ack !== 2'b00) begin
      errors++; $display("FAIL gw_check got en=%b ack=%b exp 0/00", uart_en, ack);
    end
    step();
    checks++;
    if ({uart_en, uart_wr, uart_addr, ack, err} !== 7'b11_01_01_0 || uart_data_in !== 32'h41) begin
      errors++; $display("FAIL gw_access got %b data %h exp 1101010 data 41",
                         {uart_en, uart_wr, uart_addr, ack, err}, uart_data_in);
    end
    idle_inputs();
    step();
    checks++;
    if (ack !== 2'b00 || wr_count != n0 + 1 || last_wdata !== 32'h41 || last_waddr !== 2'd1) begin
      errors++; $display("FAIL gw_after got ack=%b writes=%0d data=%h addr=%0d exp 00 %0d 41 1",
                         ack, wr_count - n0, last_wdata, last_waddr, 1);
    end
  endtask

  task test_tie_reads;
    do_reset();
    tx_full = 1'b0; rx_empty = 1'b1;
    req = 2'b11; req_wr = 2'b00; a0 = 2'd0; a1 = 2'd0;
    step();
    checks++;
    if ({uart_en, uart_wr, uart_addr, ack} !== 6'b10_00_00) begin
      errors++; $display("FAIL tie_access0 got %b exp 100000", {uart_en, uart_wr, uart_addr, ack});
    end
    step();
    checks++;
    if (ack !== 2'b01 || rdata !== 32'h40000000 || err !== 1'b0) begin
      errors++; $display("FAIL tie_ack0 got ack=%b rdata=%h err=%b exp 01 40000000 0", ack, rdata, err);
    end
    req[0] = 1'b0;
    step();
    checks++;
    if (ack !== 2'b00 || uart_en !== 1'b0) begin
      errors++; $display("FAIL tie_idle got ack=%b en=%b exp 00 0", ack, uart_en);
    end
    step();
    step();
    checks++;
    if (ack !== 2'b10 || rdata !== 32'h40000000) begin
      errors++; $display("FAIL tie_ack1 got ack=%b rdata=%h exp 10 40000000", ack, rdata);
    end
    idle_inputs();
    step();
  endtask

  task test_guard_handoff;
    do_reset();
    tx_full = 1'b0; rx_empty = 1'b1; rx_byte = 8'hA5;
    req = 2'b10; req_wr = 2'b00; a1 = 2'd1;
    step();
    req[0] = 1'b1; req_wr[0] = 1'b1; a0 = 2'd1; w0 = 32'h55;
    step();
    checks++;
    if (ack !== 2'b00 || err !== 1'b0) begin
      errors++; $display("FAIL ho_fail1 got ack=%b err=%b exp 00 0", ack, err);
    end
    step();
    checks++;
    if (uart_en !== 1'b0 || ack !== 2'b00) begin
      errors++; $display("FAIL ho_idle got en=%b ack=%b exp 0 00", uart_en, ack);
    end
    step();
    checks++;
    if ({uart_en, uart_wr, uart_addr} !== 4'b10_00) begin
      errors++; $display("FAIL ho_stat0 got %b exp 1000", {uart_en, uart_wr, uart_addr});
    end
    rx_empty = 1'b0;
    step();
    step();
    checks++;
    if (ack !== 2'b01 || uart_wr !== 1'b1 || uart_data_in !== 32'h55) begin
      errors++; $display("FAIL ho_ack0 got ack=%b wr=%b data=%h exp 01 1 55", ack, uart_wr, uart_data_in);
    end
    req[0] = 1'b0;
    for (int k = 0; k < 5; k++) step();
    checks++;
    if (ack !== 2'b10 || rdata !== 32'h000000A5 || err !== 1'b0) begin
      errors++; $display("FAIL ho_ack1 got ack=%b rdata=%h err=%b exp 10 000000a5 0", ack, rdata, err);
    end
    idle_inputs();
    step();
  endtask

  task test_max_retry;
    int  n0, cyc;
    logic early_ack, en_wr_seen;
    do_reset();
    tx_full = 1'b1;
    n0 = wr_count;
    early_ack = 1'b0; en_wr_seen = 1'b0;
    req = 2'b01; req_wr = 2'b01; a0 = 2'd1; w0 = 32'h77;
    for (int k = 1; k <= 8; k++) begin
      step();
      if (uart_en && uart_wr) en_wr_seen = 1'b1;
      if (k < 8 && ack !== 2'b00) early_ack = 1'b1;
    end
    checks++;
    if (early_ack !== 1'b0 || ack !== 2'b01 || err !== 1'b1 || rdata !== 32'd0) begin
      errors++; $display("FAIL mr_err got early=%b ack=%b err=%b rdata=%h exp 0 01 1 0",
                         early_ack, ack, err, rdata);
    end
    checks++;
    if (en_wr_seen !== 1'b0 || wr_count != n0) begin
      errors++; $display("FAIL mr_nowrite got en_wr=%b writes=%0d exp 0 0", en_wr_seen, wr_count - n0);
    end
    req = 2'b00;
    step();
    req = 2'b01;
    wait_ack(2'b01, 40, cyc);
    checks++;
    if (cyc != 8 || err !== 1'b1) begin
      errors++; $display("FAIL mr_again got cycles=%0d err=%b exp 8 1", cyc, err);
    end
    idle_inputs();
    step();
  endtask

  task test_reset_mid;
    tx_full = 1'b0; rx_empty = 1'b1;
    req = 2'b01; req_wr = 2'b01; a0 = 2'd1; w0 = 32'h99;
    step();
    step();
    checks++;
    if (ack !== 2'b00 || uart_en !== 1'b0) begin
      errors++; $display("FAIL rm_check got ack=%b en=%b exp 00 0", ack, uart_en);
    end
    reset = 1'b1;
    step();
    checks++;
    if (ack !== 2'b00 || uart_en !== 1'b0 || uart_wr !== 1'b0) begin
      errors++; $display("FAIL rm_abort got ack=%b en=%b wr=%b exp 00 0 0", ack, uart_en, uart_wr);
    end
    reset = 1'b0;
    req = 2'b11; req_wr = 2'b00; a0 = 2'd0; a1 = 2'd0;
    step();
    step();
    checks++;
    if (ack !== 2'b01) begin
      errors++; $display("FAIL rm_tie got ack=%b exp 01", ack);
    end
    idle_inputs();
    step();
    step();
    step();
  endtask

  task test_unguarded;
    do_reset();
    req = 2'b01; req_wr = 2'b00; a0 = 2'd3;
    step();
    checks++;
    if ({uart_en, uart_wr, uart_addr, ack} !== 6'b10_11_00) begin
      errors++; $display("FAIL ug_rd_access got %b exp 101100", {uart_en, uart_wr, uart_addr, ack});
    end
    step();
    checks++;
    if (ack !== 2'b01 || rdata !== 32'd0) begin
      errors++; $display("FAIL ug_rd_ack got ack=%b rdata=%h exp 01 0", ack, rdata);
    end
    req = 2'b00;
    step();
    req = 2'b01; req_wr = 2'b01; a0 = 2'd2; w0 = 32'h1234;
    step();
    checks++;
    if ({uart_en, uart_wr, uart_addr, ack} !== 6'b11_10_01 || uart_data_in !== 32'h1234) begin
      errors++; $display("FAIL ug_wr_ack got %b data %h exp 111001 1234",
                         {uart_en, uart_wr, uart_addr, ack}, uart_data_in);
    end
    idle_inputs();
    step();
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_guarded_write();
    test_tie_reads();
    test_guard_handoff();
    test_max_retry();
    test_reset_mid();
    test_unguarded();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
